// File: rtl/tick_sched_pkg.sv
// -----------------------------------------------------------------------------
// tick_sched_pkg
// Shared definitions for the tick scheduler: default sizing, the divisor
// value every channel wakes up with, the config FSM state encoding and the
// channel-index type.
// -----------------------------------------------------------------------------
package tick_sched_pkg;

  localparam int NUM_CH_DEF  = 4;
  localparam int CNT_W_DEF   = 16;
  localparam int DIV_RST_DEF = (1 << CNT_W_DEF) - 1;

  // Config handshake FSM: IDLE accepts a write, PEND holds it until the
  // target channel reaches a safe boundary.
  typedef enum logic {
    CFG_IDLE,
    CFG_PEND
  } cfgState_t;

  typedef logic [$clog2(NUM_CH_DEF)-1:0] chIdx_t;

endpackage

// File: rtl/tick_channel.sv
// -----------------------------------------------------------------------------
// tick_channel
// One tick channel: an up-counter running 0..div, its divisor register and a
// registered single-cycle tick strobe.
//
// Ports:
//   clock      system clock, rising edge
//   reset_n    synchronous active-low reset
//   i_en       run enable; low holds the counter at 0 with no tick
//   i_clr      clear counter and suppress tick (phase sync / step-mode exit)
//   i_ovr      override: counter held at 0, tick taken from i_ovrTick
//   i_ovrTick  tick value used while i_ovr is high
//   i_load     write i_loadDiv into the divisor register
//   i_loadDiv  new divisor
//   o_wrap     this edge is a normal terminal-count wrap
//   o_tick     registered tick strobe
// -----------------------------------------------------------------------------
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_ovr,
  input  logic             i_ovrTick,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_loadDiv,
  output logic             o_wrap,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic             r_tick;

  // A wrap only counts when the channel is genuinely free-running; a clear
  // or override on the same edge steals it, so no tick and no apply-on-wrap.
  assign o_wrap = i_en & ~i_clr & ~i_ovr & (r_cnt == r_div);
  assign o_tick = r_tick;

  // Counter and tick flop. Clear beats override so a phase sync silences
  // every channel, including channel 0 in step mode.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_ovr) begin
      r_cnt  <= '0;
      r_tick <= i_ovrTick;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == r_div) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_tick <= 1'b0;
    end
  end

  // Divisor register. Loads are only requested at counter restarts, so the
  // running count can never be stranded above a smaller divisor.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_div <= CNT_W'(DIV_RST);
    end else if (i_load) begin
      r_div <= i_loadDiv;
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// -----------------------------------------------------------------------------
// tick_scheduler
// Clock-enable scheduler: NUM_CH channels each emit a one-cycle tick every
// div+1 cycles. Divisors are written over a valid/ready handshake and applied
// at the target's terminal count. Channel 0 has a single-step debug mode.
//
// Ports:
//   clock      system clock, rising edge
//   reset_n    synchronous active-low reset
//   ch_en      per-channel run enable
//   cfg_valid  divisor write request
//   cfg_ready  scheduler can accept a write (registered)
//   cfg_ch     target channel of the write
//   cfg_div    new divisor (period = div+1)
//   cfg_sync   one-cycle pulse: clear every counter, apply any pending write
//   step_mode  channel 0 ticks only on rising edges of step_req
//   step_req   step request level
//   tick       registered tick strobes
// -----------------------------------------------------------------------------
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = (1 << CNT_W) - 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]          cfg_div,
  input  logic                      cfg_sync,
  input  logic                      step_mode,
  input  logic                      step_req,
  output logic [NUM_CH-1:0]         tick
);

  localparam int IDX_W = $clog2(NUM_CH);

  cfgState_t        r_state;
  logic             r_cfgReady;
  logic [IDX_W-1:0] r_pendCh;
  logic [CNT_W-1:0] r_pendDiv;
  logic             r_stepPrev;
  logic             r_stepModeD;

  logic [NUM_CH-1:0] w_wrap;
  logic [NUM_CH-1:0] w_load;
  logic [NUM_CH-1:0] w_tick;
  logic              w_apply;
  logic              w_stepEdge;
  logic              w_modeExit;

  assign cfg_ready = r_cfgReady;
  assign tick      = w_tick;

  // The pending divisor lands when its channel wraps, sits disabled, or a
  // phase sync restarts everything -- all points where the counter is at 0.
  assign w_apply = (r_state == CFG_PEND) &
                   (w_wrap[r_pendCh] | ~ch_en[r_pendCh] | cfg_sync);

  assign w_stepEdge = step_req & ~r_stepPrev;

  // Leaving step mode restarts channel 0 from 0; entering is covered by the
  // override, which already holds the counter at 0.
  assign w_modeExit = r_stepModeD & ~step_mode;

  // Config FSM with registered ready. Ready stays low through reset and
  // rises on the first released edge; out-of-range writes are swallowed.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= CFG_IDLE;
      r_cfgReady <= 1'b0;
      r_pendCh   <= '0;
      r_pendDiv  <= '0;
    end else begin
      case (r_state)
        CFG_IDLE: begin
          r_cfgReady <= 1'b1;
          if (cfg_valid && r_cfgReady && (int'(cfg_ch) < NUM_CH)) begin
            r_pendCh   <= cfg_ch;
            r_pendDiv  <= cfg_div;
            r_state    <= CFG_PEND;
            r_cfgReady <= 1'b0;
          end
        end
        CFG_PEND: begin
          if (w_apply) begin
            r_state    <= CFG_IDLE;
            r_cfgReady <= 1'b1;
          end
        end
        default: begin
          r_state    <= CFG_IDLE;
          r_cfgReady <= 1'b0;
        end
      endcase
    end
  end

  // Previous-cycle copies of step_req and step_mode for edge detection.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_stepPrev  <= 1'b0;
      r_stepModeD <= 1'b0;
    end else begin
      r_stepPrev  <= step_req;
      r_stepModeD <= step_mode;
    end
  end

  // Channel array; only channel 0 sees the step-mode override and clear.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_load[i] = w_apply & (r_pendCh == IDX_W'(i));
    if (i == 0) begin : g_step
      tick_channel #(
        .CNT_W   (CNT_W),
        .DIV_RST (DIV_RST)
      ) u_ch (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_en      (ch_en[i]),
        .i_clr     (cfg_sync | w_modeExit),
        .i_ovr     (step_mode),
        .i_ovrTick (w_stepEdge),
        .i_load    (w_load[i]),
        .i_loadDiv (r_pendDiv),
        .o_wrap    (w_wrap[i]),
        .o_tick    (w_tick[i])
      );
    end else begin : g_plain
      tick_channel #(
        .CNT_W   (CNT_W),
        .DIV_RST (DIV_RST)
      ) u_ch (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_en      (ch_en[i]),
        .i_clr     (cfg_sync),
        .i_ovr     (1'b0),
        .i_ovrTick (1'b0),
        .i_load    (w_load[i]),
        .i_loadDiv (r_pendDiv),
        .o_wrap    (w_wrap[i]),
        .o_tick    (w_tick[i])
      );
    end
  end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Synchronous clock-enable scheduler that replaces ripple-divided clocks with single-cycle `tick` strobes on the system `clock`. It drives the 7-segment refresh, the CPU step enable and other slow consumers. It holds one programmable divisor per channel and accepts divisor updates over a valid/ready handshake, applying each update glitch-free at the target channel's terminal count. Channel 0 also supports a single-step mode for CPU debug.

## Interface
Parameters:
- `NUM_CH`, 4, number of tick channels (2..8)
- `CNT_W`, 16, divisor/counter width
- `DIV_RST`, 2**CNT_W-1, divisor loaded into every channel at reset (period 65536 cycles)

Ports:
- `clock`  in  1  single system clock, all logic on rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `ch_en`  in  NUM_CH  per-channel run enable
- `cfg_valid`  in  1  divisor write request
- `cfg_ready`  out  1  scheduler can accept a write
- `cfg_ch`  in  $clog2(NUM_CH)  target channel
- `cfg_div`  in  CNT_W  new divisor (period = div+1 cycles)
- `cfg_sync`  in  1  one-cycle pulse: phase-align all channels
- `step_mode`  in  1  channel 0 ticks only on `step_req`
- `step_req`  in  1  synchronous step request (level; rising edge counts)
- `tick`  out  NUM_CH  one-cycle enable strobes, registered

## Operation
- Per channel: `cnt` counts 0..`div`. On the edge where `cnt==div` and `ch_en` is 1: `cnt<=0`, `tick<=1`; otherwise `tick<=0`, `cnt<=cnt+1`. `div=0` gives a tick every cycle.
- `ch_en` low: `cnt` forced to 0 and `tick` held 0. Re-enable restarts from 0.
- Config FSM, states IDLE and PEND:
  - IDLE: `cfg_ready=1`. `cfg_valid` captures `cfg_ch`/`cfg_div` into the pending slot and moves to PEND.
  - PEND: `cfg_ready=0`. On the edge where the target channel wraps (`cnt==div`, enabled), the target is disabled, or `cfg_sync` is high, the pending divisor is written into that channel's `div` and the FSM returns to IDLE.
- `cfg_ch >= NUM_CH`: write is accepted and discarded, and the FSM stays in IDLE.
- `cfg_sync`: every `cnt` is cleared to 0 on that edge and `tick` is 0 in the next cycle. If a wrap coincides with `cfg_sync`, sync wins and no tick is issued.
- Step mode (`step_mode=1`):
  - Channel 0 counter is held at 0.
  - `tick[0]` pulses once per rising edge of `step_req` (registered previous value, `step_req & ~prev`), regardless of `ch_en[0]` and `div[0]`.
  - Holding `step_req` high gives exactly one tick.
  - Toggling `step_mode` either way clears `cnt[0]`.
- Arithmetic is unsigned with CNT_W bits. `cnt` never exceeds `div`. A divisor shrunk below the running `cnt` cannot occur, because updates apply only at `cnt==0` boundaries.

## Timing
- Reset (`reset_n=0` sampled): `tick=0`, `cfg_ready=0`, all `cnt=0`, all `div=DIV_RST`, FSM=IDLE, pending slot cleared, step edge register=0.
- `cfg_ready` rises on the first edge with `reset_n=1`.
- First tick after reset release or enable: `tick` high after edge `div+1` (counting the first enabled edge as 1), then every `div+1` edges.
- Config latency:
  - New period takes effect on the cycle after the apply edge.
  - The tick produced at the apply edge still belongs to the old period.
  - Disabled target: applied on the edge after acceptance.
- Step latency: `tick[0]` high in the cycle after the edge that first samples `step_req=1`.
- Reset mid-PEND drops the pending write. Reset mid-period truncates the period with no tick.

## Structure
- Package `tick_sched_pkg`:
  - `CNT_W` and `NUM_CH` defaults
  - `DIV_RST`
  - config FSM state enum (`CFG_IDLE`, `CFG_PEND`)
  - channel-index type
- Sub-module `tick_channel`: one counter, divisor register, load port, enable, sync clear and tick flop. Instantiated NUM_CH times.
- The top level holds the config FSM, pending slot and step edge detect. Channel 0 gets the extra step-mode muxing at the top level.

## Test plan
- Reset, `ch_en=4'b0001`, `DIV_RST` overridden to 3 → `tick[0]` high after edges 4, 8, 12. Other ticks stay 0 and `cfg_ready=1` after the first edge.
- Ch0 running `div=9`; write ch0 `div=2` at `cnt=4` → `cfg_ready` low for 5 cycles. The old tick arrives, then ticks every 3 cycles.
- Write to disabled ch2 (`div=0`), then enable → `cfg_ready` low for 1 cycle, and `tick[2]` high every cycle after enable.
- Ch0 `div=7`, ch1 `div=3` with ch1 at `cnt=2`; assert `cfg_sync` → both counters cleared with no tick that cycle. Ticks then coincide every 8 cycles.
- `step_mode=1`, `step_req` held high 10 cycles, then low, then high again → exactly two single-cycle `tick[0]` pulses, each one cycle after its rising edge.
- `reset_n` low for one cycle while in PEND → pending write dropped, `div` stays at `DIV_RST`, and `cfg_ready` returns high on the next edge.
